matmul_result_reader: RTL and testbench
=======================================

MATMUL_RESULT_READER -- requirements
Module: matmul_result_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, meaning the width of one result element in bits.
REQ-002 SHALL have parameter AWIDTH, default 11, meaning the width of the result-RAM address.
REQ-003 SHALL have parameter MAT_MUL_SIZE, default 8, meaning the matrix dimension (rows and columns).
REQ-004 SHALL have a single clock and an asynchronous, active-high reset; the ports are as follows.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 done_mat_mul  input  1  level from the multiplier; high means matrix C is complete in RAM.
REQ-008 clear_done  output  1  request to the multiplier to drop done_mat_mul.
REQ-009 address_mat_c  input  AWIDTH  RAM address of row 0 of C.
REQ-010 address_stride_c  input  8  address increment between consecutive rows of C.
REQ-011 validity_mask_a_rows  input  MAT_MUL_SIZE  bit r=1 means row r of C is valid.
REQ-012 validity_mask_b_cols  input  MAT_MUL_SIZE  bit c=1 means column c of C is valid.
REQ-013 bram_addr  output  AWIDTH  read address to the result RAM.
REQ-014 bram_en  output  1  read enable; the RAM returns data exactly one cycle after an enabled cycle.
REQ-015 bram_rdata  input  MAT_MUL_SIZE*DWIDTH  one row word; element c is bits [c*DWIDTH +: DWIDTH].
REQ-016 out_data  output  DWIDTH  streamed result element.
REQ-017 out_valid  output  1  out_data is valid.
REQ-018 out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are high on a rising edge.
REQ-019 out_last  output  1  marks the final element of the matrix; valid only with out_valid.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, READ, WAIT, STREAM and CLEAR.
REQ-022 In IDLE, a sampled done_mat_mul=1 SHALL capture address_mat_c, address_stride_c and both masks into internal registers, and SHALL move the FSM to READ with row counter set to the lowest valid row.
REQ-023 Input changes after capture SHALL have no effect until the next return to IDLE.
REQ-024 If either captured mask is all-zero, the FSM SHALL go directly from IDLE to CLEAR and stream nothing.
REQ-025 READ SHALL last exactly one cycle, with bram_en=1 and bram_addr=(base + row*stride) mod 2^AWIDTH, then go to WAIT.
REQ-026 WAIT SHALL last one cycle, then go to STREAM, registering bram_rdata into a row buffer on entry to STREAM.
REQ-027 STREAM SHALL present the row-buffer elements in ascending column order, valid columns only, with out_valid=1.
REQ-028 STREAM SHALL hold out_data, out_valid and out_last stable while out_ready=0.
REQ-029 STREAM SHALL advance one element per accepted transfer, giving one element per cycle when out_ready stays high.
REQ-030 After the last valid column of a row, STREAM SHALL go to READ for the next valid row, skipping invalid rows; otherwise it SHALL go to CLEAR.
REQ-031 out_last SHALL be 1 only on the last valid column of the last valid row.
REQ-032 bram_en SHALL be 0 outside READ, and bram_addr SHALL hold its last value.
REQ-033 CLEAR SHALL assert clear_done=1 until done_mat_mul is sampled 0, then SHALL return to IDLE with clear_done=0 in the following cycle.
REQ-034 done_mat_mul falling mid-transfer SHALL NOT abort the transfer.
REQ-035 The block SHALL output each matrix exactly once, so a new matrix requires done_mat_mul to go low and then high again.
REQ-036 Throughput SHALL be 2 overhead cycles (READ, WAIT) per valid row plus one cycle per valid element under continuous out_ready.

Reset
REQ-037 Asserting reset at any time, including mid-stream, SHALL immediately force IDLE, out_valid=0, out_last=0, out_data=0, bram_en=0, bram_addr=0, clear_done=0, busy=0, and clear all counters and captured registers.
REQ-038 After reset deasserts, the block SHALL wait in IDLE and SHALL act only on a sampled done_mat_mul=1, even if done_mat_mul was already high during reset.

Verification
REQ-039 Full 8x8 transfer: base=0, stride=8, masks=8'hFF, RAM rows all 8'h08, out_ready=1 -> 64 transfers of 8'h08, bram_addr 0,8,...,56, out_last only on transfer 64, then a clear_done pulse.
REQ-040 Masked transfer: rows=8'b00000101, cols=8'b10000001 -> 4 transfers (row0 col0, row0 col7, row2 col0, row2 col7), reads at base and base+2*stride only.
REQ-041 Backpressure: out_ready toggling 1,0,0,1 -> data held stable across stalls, no element lost or duplicated, element order unchanged.
REQ-042 Address wrap: base=11'h7FC, stride=8 -> row1 read at address 11'h004.
REQ-043 Reset mid-stream after 10 transfers -> all outputs reach their reset values without waiting for a clock edge; a new done_mat_mul pulse then restarts from row 0.
REQ-044 All-zero column mask -> no out_valid, and clear_done asserts the cycle after done_mat_mul is sampled.

Source files
------------

// File: rtl/matmul_result_reader_if.sv
// matmul_result_reader_if: multiplier handshake, result-RAM read port and output stream of the result reader
interface matmul_result_reader_if #(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 11,
  parameter int MAT_MUL_SIZE = 8
);
  logic                           done_mat_mul;
  logic                           clear_done;
  logic [AWIDTH-1:0]              address_mat_c;
  logic [7:0]                     address_stride_c;
  logic [MAT_MUL_SIZE-1:0]        validity_mask_a_rows;
  logic [MAT_MUL_SIZE-1:0]        validity_mask_b_cols;
  logic [AWIDTH-1:0]              bram_addr;
  logic                           bram_en;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata;
  logic [DWIDTH-1:0]              out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_last;
  logic                           busy;
  modport master (
    input  done_mat_mul, address_mat_c, address_stride_c, validity_mask_a_rows,
           validity_mask_b_cols, bram_rdata, out_ready,
    output clear_done, bram_addr, bram_en, out_data, out_valid, out_last, busy
  );
  modport slave (
    output done_mat_mul, address_mat_c, address_stride_c, validity_mask_a_rows,
           validity_mask_b_cols, bram_rdata, out_ready,
    input  clear_done, bram_addr, bram_en, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/matmul_result_reader.sv
// matmul_result_reader: reads the valid rows of matrix C from result RAM and streams the valid elements in row-major order
module matmul_result_reader #(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 11,
  parameter int MAT_MUL_SIZE = 8
) (
  input logic                   clk,
  input logic                   reset,
  matmul_result_reader_if.master m
);
  localparam int IW = MAT_MUL_SIZE > 1 ? $clog2(MAT_MUL_SIZE) : 1;
  localparam int PW = AWIDTH + IW + 9;
  typedef enum logic [2:0] {IDLE, READ, WAIT, STREAM, CLEAR} state_t;
  state_t                         r_state;
  logic [AWIDTH-1:0]              r_base;
  logic [7:0]                     r_stride;
  logic [MAT_MUL_SIZE-1:0]        r_rmask;
  logic [MAT_MUL_SIZE-1:0]        r_cmask;
  logic [IW-1:0]                  r_row;
  logic [IW-1:0]                  r_col;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] r_buf;
  logic [IW:0]                    w_row0;
  logic [IW:0]                    w_nrow;
  logic [IW:0]                    w_col0;
  logic [IW:0]                    w_ncol;
  logic [IW:0]                    w_after;
  logic [IW-1:0]                  w_col;
  logic                           w_last;
  // {found, index} of the lowest set bit of mask at or above start
  function automatic logic [IW:0] find_from(input logic [MAT_MUL_SIZE-1:0] mask, input int start);
    logic [IW:0] r;
    r = '0;
    for (int i = MAT_MUL_SIZE - 1; i >= 0; i--)
      if (mask[i] && i >= start) r = {1'b1, IW'(i)};
    return r;
  endfunction
  function automatic logic [AWIDTH-1:0] row_addr(input logic [AWIDTH-1:0] base,
                                                 input logic [7:0] stride, input logic [IW-1:0] row);
    logic [PW-1:0] t;
    t = PW'(base) + PW'(stride) * PW'(row);
    return t[AWIDTH-1:0];
  endfunction
  always_comb begin
    w_row0  = find_from(m.validity_mask_a_rows, 0);
    w_nrow  = find_from(r_rmask, int'(r_row) + 1);
    w_col0  = find_from(r_cmask, 0);
    w_ncol  = find_from(r_cmask, int'(r_col) + 1);
    w_col   = r_state == WAIT ? w_col0[IW-1:0] : w_ncol[IW-1:0];
    w_after = find_from(r_cmask, int'(w_col) + 1);
    w_last  = !w_after[IW] && !w_nrow[IW];
  end
  assign m.busy = r_state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_stride     <= '0;
      r_rmask      <= '0;
      r_cmask      <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_buf        <= '0;
      m.bram_en    <= 1'b0;
      m.bram_addr  <= '0;
      m.out_data   <= '0;
      m.out_valid  <= 1'b0;
      m.out_last   <= 1'b0;
      m.clear_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (m.done_mat_mul) begin
          r_base   <= m.address_mat_c;
          r_stride <= m.address_stride_c;
          r_rmask  <= m.validity_mask_a_rows;
          r_cmask  <= m.validity_mask_b_cols;
          if (m.validity_mask_a_rows == '0 || m.validity_mask_b_cols == '0) begin
            m.clear_done <= 1'b1;
            r_state      <= CLEAR;
          end else begin
            r_row       <= w_row0[IW-1:0];
            m.bram_en   <= 1'b1;
            m.bram_addr <= row_addr(m.address_mat_c, m.address_stride_c, w_row0[IW-1:0]);
            r_state     <= READ;
          end
        end
        READ: begin
          m.bram_en <= 1'b0;
          r_state   <= WAIT;
        end
        WAIT: begin
          r_buf       <= m.bram_rdata;
          r_col       <= w_col;
          m.out_data  <= m.bram_rdata[w_col*DWIDTH +: DWIDTH];
          m.out_valid <= 1'b1;
          m.out_last  <= w_last;
          r_state     <= STREAM;
        end
        STREAM: if (m.out_ready) begin
          if (w_ncol[IW]) begin
            r_col      <= w_col;
            m.out_data <= r_buf[w_col*DWIDTH +: DWIDTH];
            m.out_last <= w_last;
          end else begin
            m.out_valid <= 1'b0;
            m.out_last  <= 1'b0;
            if (w_nrow[IW]) begin
              r_row       <= w_nrow[IW-1:0];
              m.bram_en   <= 1'b1;
              m.bram_addr <= row_addr(r_base, r_stride, w_nrow[IW-1:0]);
              r_state     <= READ;
            end else begin
              m.clear_done <= 1'b1;
              r_state      <= CLEAR;
            end
          end
        end
        CLEAR: if (!m.done_mat_mul) begin
          m.clear_done <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_result_reader.sv
// tb_matmul_result_reader: directed vectors and corner-case sequences for the result reader
module tb_matmul_result_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ram_const = 1'b0;
  int tests = 0;
  int failed = 0;
  always #5 clk = ~clk;
  matmul_result_reader_if #(.DWIDTH(8), .AWIDTH(11), .MAT_MUL_SIZE(8)) m ();
  matmul_result_reader #(.DWIDTH(8), .AWIDTH(11), .MAT_MUL_SIZE(8)) dut (.clk(clk), .reset(reset), .m(m));
  typedef struct {
    logic [10:0] base;
    logic [7:0]  stride;
    logic [7:0]  rm;
    logic [7:0]  cm;
    logic        cst;
    logic [3:0]  rdy;
    logic        early;
    int          n;
    int          reads;
    logic [10:0] a0;
    logic [10:0] a1;
    int          active;
  } vec_t;
  vec_t v[6];
  logic [7:0]  got_d[$];
  logic        got_l[$];
  logic [10:0] got_a[$];
  function automatic logic [7:0] elem(input logic [10:0] a, input int c);
    return 8'(a) + 8'(c * 16);
  endfunction
  always @(posedge clk)
    if (m.bram_en)
      for (int c = 0; c < 8; c++) m.bram_rdata[c*8 +: 8] <= ram_const ? 8'h08 : elem(m.bram_addr, c);
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(m.out_valid), 0);
    check({tag, "_last"}, 32'(m.out_last), 0);
    check({tag, "_data"}, 32'(m.out_data), 0);
    check({tag, "_en"}, 32'(m.bram_en), 0);
    check({tag, "_addr"}, 32'(m.bram_addr), 0);
    check({tag, "_clear"}, 32'(m.clear_done), 0);
    check({tag, "_busy"}, 32'(m.busy), 0);
  endtask
  task automatic run(input vec_t t, input int id);
    int cyc = 0;
    int act = 0;
    int clears = 0;
    int stall_err = 0;
    int k = 0;
    int j = 0;
    logic pv = 0;
    logic pr = 0;
    logic pl = 0;
    logic [7:0] pd = 0;
    logic [7:0] ed;
    logic [10:0] a;
    got_d.delete();
    got_l.delete();
    got_a.delete();
    @(negedge clk);
    m.address_mat_c = t.base;
    m.address_stride_c = t.stride;
    m.validity_mask_a_rows = t.rm;
    m.validity_mask_b_cols = t.cm;
    ram_const = t.cst;
    m.done_mat_mul = 1'b1;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      m.out_ready = t.rdy[cyc % 4];
      if (pv && !pr && (m.out_valid !== 1'b1 || m.out_data !== pd || m.out_last !== pl)) stall_err++;
      if (m.bram_en) got_a.push_back(m.bram_addr);
      if (m.out_valid && m.out_ready) begin
        got_d.push_back(m.out_data);
        got_l.push_back(m.out_last);
        if (t.early) m.done_mat_mul = 1'b0;
      end
      if (m.busy && !m.clear_done) act++;
      if (m.clear_done) begin
        clears++;
        m.done_mat_mul = 1'b0;
      end
      pv = m.out_valid;
      pr = m.out_ready;
      pd = m.out_data;
      pl = m.out_last;
      if (clears > 0 && !m.busy) break;
    end
    $display("[TB] vector %0d: %0d transfers, %0d reads, %0d cycles", id, got_d.size(), got_a.size(), cyc);
    check("timeout", 32'(cyc < 2000), 1);
    check("n_transfers", got_d.size(), t.n);
    check("n_reads", got_a.size(), t.reads);
    check("clear_pulse", clears, 1);
    check("stall_hold", stall_err, 0);
    if (got_a.size() > 0) check("addr0", 32'(got_a[0]), 32'(t.a0));
    if (t.reads > 1 && got_a.size() > 1) check("addr1", 32'(got_a[1]), 32'(t.a1));
    if (t.active > 0) check("throughput", act, t.active);
    for (int r = 0; r < 8; r++) if (t.rm[r]) begin
      a = t.base + 11'(r) * 11'(t.stride);
      if (j < got_a.size()) check("row_addr", 32'(got_a[j]), 32'(a));
      j++;
      for (int c = 0; c < 8; c++) if (t.cm[c]) begin
        ed = t.cst ? 8'h08 : elem(a, c);
        if (k < got_d.size()) begin
          check("data", 32'(got_d[k]), 32'(ed));
          check("last", 32'(got_l[k]), 32'(k == t.n - 1));
        end
        k++;
      end
    end
  endtask
  initial begin
    int cnt;
    int cyc;
    vec_t rv;
    v[0] = '{base: 11'h000, stride: 8'd8,  rm: 8'hFF, cm: 8'hFF, cst: 1'b1, rdy: 4'hF, early: 1'b0,
             n: 64, reads: 8, a0: 11'h000, a1: 11'h008, active: 80};
    v[1] = '{base: 11'h010, stride: 8'd8,  rm: 8'h05, cm: 8'h81, cst: 1'b0, rdy: 4'hF, early: 1'b0,
             n: 4,  reads: 2, a0: 11'h010, a1: 11'h020, active: 8};
    v[2] = '{base: 11'h100, stride: 8'h10, rm: 8'h03, cm: 8'h0F, cst: 1'b0, rdy: 4'b1001, early: 1'b0,
             n: 8,  reads: 2, a0: 11'h100, a1: 11'h110, active: 0};
    v[3] = '{base: 11'h7FC, stride: 8'd8,  rm: 8'h03, cm: 8'hFF, cst: 1'b0, rdy: 4'hF, early: 1'b0,
             n: 16, reads: 2, a0: 11'h7FC, a1: 11'h004, active: 20};
    v[4] = '{base: 11'h005, stride: 8'd3,  rm: 8'h90, cm: 8'h40, cst: 1'b0, rdy: 4'hF, early: 1'b0,
             n: 2,  reads: 2, a0: 11'h011, a1: 11'h01A, active: 6};
    v[5] = '{base: 11'h000, stride: 8'd1,  rm: 8'h01, cm: 8'h03, cst: 1'b0, rdy: 4'hF, early: 1'b1,
             n: 2,  reads: 1, a0: 11'h000, a1: 11'h000, active: 4};
    m.done_mat_mul = 1'b0;
    m.address_mat_c = '0;
    m.address_stride_c = '0;
    m.validity_mask_a_rows = '0;
    m.validity_mask_b_cols = '0;
    m.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) run(v[i], i);
    @(negedge clk);
    m.validity_mask_a_rows = 8'hFF;
    m.validity_mask_b_cols = 8'h00;
    m.done_mat_mul = 1'b1;
    @(negedge clk);
    check("zmask_clear", 32'(m.clear_done), 1);
    check("zmask_valid", 32'(m.out_valid), 0);
    check("zmask_busy", 32'(m.busy), 1);
    check("zmask_en", 32'(m.bram_en), 0);
    m.done_mat_mul = 1'b0;
    @(negedge clk);
    check("zmask_clear_drop", 32'(m.clear_done), 0);
    check("zmask_idle", 32'(m.busy), 0);
    repeat (3) @(negedge clk);
    check("no_retrigger_busy", 32'(m.busy), 0);
    check("no_retrigger_en", 32'(m.bram_en), 0);
    m.address_mat_c = 11'h000;
    m.address_stride_c = 8'd8;
    m.validity_mask_a_rows = 8'hFF;
    m.validity_mask_b_cols = 8'hFF;
    ram_const = 1'b1;
    m.out_ready = 1'b1;
    m.done_mat_mul = 1'b1;
    cnt = 0;
    cyc = 0;
    while (cnt < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (m.out_valid && m.out_ready) cnt++;
    end
    check("mid_transfers", cnt, 10);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    m.done_mat_mul = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rv = v[0];
    rv.base = 11'h040;
    rv.a0 = 11'h040;
    rv.a1 = 11'h048;
    run(rv, 6);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
